muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Multi-cycle sequencer for the RV32M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) that the decoder classifies as M-extension ALU ops. It sits beside the single-cycle ALU in the execute stage. It accepts operands when the decoder flags an M op and stalls the pipeline while a radix-2 iterative shift-add multiplier or restoring divider runs. It returns one 32-bit result with a one-cycle valid pulse.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.

- i_clk  in  1  single clock, all state updates on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  M op present in EX; sampled only in IDLE
- i_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_rs1  in  XLEN  operand a (multiplicand/dividend)
- i_rs2  in  XLEN  operand b (multiplier/divisor)
- i_flush  in  1  kill the in-flight op (branch/jump redirect)
- o_stall  out  1  hold PC/IF/ID/EX
- o_busy  out  1  state != IDLE
- o_valid  out  1  one-cycle result strobe
- o_result  out  XLEN  result; held until next o_valid

## Operation
- FSM states: IDLE, PREP, CALC, FIX, DONE.
- IDLE: on i_start & !i_flush, latch i_op, i_rs1 and i_rs2, then go to PREP.
- PREP:
  - Compute operand signs. MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats a as signed and b as unsigned. MULHU/DIVU/REMU treat both as unsigned.
  - Replace signed negatives with their two's-complement magnitude.
  - Load 6-bit iteration counter with 32.
  - Divide-by-zero (b==0, div/rem ops) goes directly to DONE with these results: quotient = 0xFFFFFFFF (DIV and DIVU), remainder = a unmodified.
  - Signed overflow (DIV/REM, a==0x80000000, b==0xFFFFFFFF) goes directly to DONE with quotient 0x80000000 and remainder 0.
  - Otherwise go to CALC.
- CALC: one iteration per cycle; decrement counter; go to FIX when counter reaches 0 (exactly 32 cycles).
  - Multiply: 64-bit accumulator; if multiplier LSB set, add multiplicand to upper half; shift right 1.
  - Divide: restoring. Shift {rem,quot} left 1; subtract divisor from rem; if result non-negative keep it and set quot LSB, else restore.
- FIX:
  - Multiply: negate the 64-bit product if operand signs differ (signed cases only). MUL selects the low 32 bits; the MULH variants select the high 32 bits.
  - Divide: negate quotient if sign(a)^sign(b) (signed only); negate remainder if sign(a) (signed only). DIV/DIVU select quotient, REM/REMU select remainder.
  - Register o_result; go to DONE.
- DONE: o_valid=1; next state IDLE unconditionally. i_start is ignored in DONE, so an EX instruction still present does not retrigger.
- o_stall = (IDLE & i_start & !i_flush) | PREP | CALC | FIX. It is low in DONE so the pipeline advances and captures o_result.
- i_flush in any non-IDLE state: next state IDLE, no o_valid, o_result unchanged. Flush has priority over start.
- Arithmetic is modulo 2^32/2^64. The most-negative operand magnitude 0x80000000 is handled as unsigned 33-bit safe.

## Timing
- Reset (async, immediate): state IDLE; o_stall=0, o_busy=0, o_valid=0, o_result=0; counter and datapath registers cleared.
- For a start accepted at edge k:
  - PREP occupies cycle k+1, CALC cycles k+2..k+33, FIX cycle k+34.
  - DONE/o_valid occurs in cycle k+35, so latency is 35 cycles.
- Special divide cases: DONE in cycle k+2, so latency is 2 cycles.
- o_stall is high from the start cycle through the cycle before DONE (35 cycles normal, 2 cycles special).
- Back-to-back: the earliest next start is accepted in the IDLE cycle after DONE.
- Reset asserted mid-op aborts with no valid. Operation resumes on the first edge after deassertion, in IDLE.

## Test plan
- MUL 7 × 0xFFFFFFFD -> o_result 0xFFFFFFEB, o_valid exactly in cycle 35 after start, o_stall high cycles 0..34.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/16 -> 0x0FFFFFFF; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with valid 2 cycles after start. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Flush in cycle 10 of a DIV -> IDLE next cycle, no o_valid, o_result keeps its prior value. A new MUL start the following cycle completes normally.
- i_start held high through DONE -> no second operation. Async i_rst pulse mid-CALC -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer: radix-2 shift-add multiplier and restoring divider
// sharing one 64-bit accumulator, with a one-cycle result strobe and pipeline stall.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic [2:0]      o_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     a_q;
    logic [XLEN-1:0]     b_q;
    logic                neg_q;
    logic                neg_rem_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [5:0]          cnt_q;

    logic                is_div;
    logic                sgn_a_op;
    logic                sgn_b_op;
    logic                a_neg;
    logic                b_neg;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic                div_zero;
    logic                div_ovf;
    logic [XLEN-1:0]     special_res;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_part;
    logic [XLEN:0]       div_diff;
    logic [2*XLEN-1:0]   div_next;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quot;
    logic [XLEN-1:0]     rem;
    logic [XLEN-1:0]     fix_res;

    // Operand classification; a_q/b_q still hold the raw operands while in PREP.
    always_comb begin
        is_div   = op_q[2];
        sgn_a_op = (op_q == 3'b000) || (op_q == 3'b001) || (op_q == 3'b010) ||
                   (op_q == 3'b100) || (op_q == 3'b110);
        sgn_b_op = (op_q == 3'b000) || (op_q == 3'b001) ||
                   (op_q == 3'b100) || (op_q == 3'b110);
        a_neg    = sgn_a_op & a_q[XLEN-1];
        b_neg    = sgn_b_op & b_q[XLEN-1];
        a_mag    = a_neg ? (~a_q + 1'b1) : a_q;
        b_mag    = b_neg ? (~b_q + 1'b1) : b_q;
        div_zero = is_div && (b_q == '0);
        div_ovf  = is_div && !op_q[0] && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (&b_q);
        special_res = '0;
        if (div_zero) begin
            special_res = op_q[1] ? a_q : '1;
        end else if (div_ovf) begin
            special_res = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One iteration of each algorithm; the divider compares a 33-bit partial remainder.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, a_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
        div_part = acc_q[2*XLEN-1:XLEN-1];
        div_diff = div_part - {1'b0, b_q};
        div_next = div_diff[XLEN] ? {div_part[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    always_comb begin
        prod = neg_q ? (~acc_q + 1'b1) : acc_q;
        quot = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        if (is_div) begin
            fix_res = op_q[1] ? rem : quot;
        end else begin
            fix_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (i_start && !i_flush) state_d = S_PREP;
            S_PREP: state_d = (div_zero || div_ovf) ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == 6'd1) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (i_flush && (state_q != S_IDLE)) state_d = S_IDLE;
    end

    always_comb begin
        o_busy  = (state_q != S_IDLE);
        o_valid = (state_q == S_DONE) && !i_flush;
        o_stall = ((state_q == S_IDLE) && i_start && !i_flush) ||
                  (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX);
        o_state = state_q;
    end

    // o_result is only written when the op is not being flushed, so it holds otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            o_result  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start && !i_flush) begin
                        op_q <= i_op;
                        a_q  <= i_rs1;
                        b_q  <= i_rs2;
                    end
                end
                S_PREP: begin
                    a_q       <= a_mag;
                    b_q       <= b_mag;
                    neg_q     <= a_neg ^ b_neg;
                    neg_rem_q <= a_neg;
                    cnt_q     <= 6'(XLEN);
                    acc_q     <= is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
                    if ((div_zero || div_ovf) && !i_flush) o_result <= special_res;
                end
                S_CALC: begin
                    cnt_q <= cnt_q - 6'd1;
                    acc_q <= is_div ? div_next : mul_next;
                end
                S_FIX: begin
                    if (!i_flush) o_result <= fix_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV32M corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [2:0]  i_op;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic        i_flush;
    logic        o_stall;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_result;
    logic [2:0]  o_state;

    int n_checks;
    int n_fail;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;

    muldiv_seq dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_flush  (i_flush),
        .o_stall  (o_stall),
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .o_result (o_result),
        .o_state  (o_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // reference model: plain 64-bit arithmetic and SV integer division
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        if (!op[2]) begin
            ea = (op == 3'b011) ? {32'h0, a} : {{32{a[31]}}, a};
            eb = (op == 3'b011 || op == 3'b010) ? {32'h0, b} : {{32{b[31]}}, b};
            p  = ea * eb;
            return (op == 3'b000) ? p[31:0] : p[63:32];
        end
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2] && (b == 32'h0)) return 2;
        if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 35;
    endfunction

    // driver: start an op, follow it to o_valid, score latency, stall span and result
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold_start);
        int lat;
        int stall_cnt;
        bit seen;
        logic [31:0] exp;
        @(negedge clk);
        i_start = 1'b1;
        i_op    = op;
        i_rs1   = a;
        i_rs2   = b;
        #1;
        stall_cnt = o_stall ? 1 : 0;
        lat  = 0;
        seen = 1'b0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (!hold_start) i_start = 1'b0;
            #1;
            if (o_valid) begin
                seen = 1'b1;
                break;
            end
            if (o_stall) stall_cnt++;
        end
        exp = exp_q.pop_front();
        check("valid_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'(ref_latency(op, a, b)));
        check("stall_span", 32'(stall_cnt), 32'(ref_latency(op, a, b)));
        check("stall_in_done", 32'(o_stall), 32'd0);
        check("result", o_result, exp);
        last_res = exp;
        @(negedge clk);
        i_start = 1'b0;
        #1;
        check("valid_pulse_len", 32'(o_valid), 32'd0);
        if (hold_start) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                #1;
                check("no_retrigger", 32'(o_busy), 32'd0);
            end
        end
    endtask

    task automatic run_checked(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp);
        exp_q.push_back(exp);
        do_op(op, a, b, 1'b0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        n_checks = 0;
        n_fail   = 0;
        last_res = 32'h0;
        rst      = 1'b1;
        i_start  = 1'b0;
        i_op     = 3'b000;
        i_rs1    = 32'h0;
        i_rs2    = 32'h0;
        i_flush  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", 32'(o_stall), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_result", o_result, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // directed values taken from the RV32M definitions
        run_checked(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_checked(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_checked(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_checked(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_checked(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        run_checked(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        run_checked(3'b101, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF);
        run_checked(3'b111, 32'd100,       32'd7,         32'd2);
        run_checked(3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF);
        run_checked(3'b111, 32'd5,         32'd0,         32'd5);
        run_checked(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_checked(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

        // flush in cycle 10 of a DIV, then a MUL starting the very next cycle
        @(negedge clk);
        i_start = 1'b1;
        i_op    = 3'b100;
        i_rs1   = 32'd1000;
        i_rs2   = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        i_flush = 1'b1;
        #1;
        check("flush_valid", 32'(o_valid), 32'd0);
        @(negedge clk);
        i_flush = 1'b0;
        #1;
        check("flush_idle", 32'(o_busy), 32'd0);
        check("flush_hold_result", o_result, last_res);
        check("flush_no_valid", 32'(o_valid), 32'd0);
        run_checked(3'b000, 32'd12345, 32'd678, 32'd8369910);

        // start held high through DONE must not launch a second op
        exp_q.push_back(ref_model(3'b011, 32'hDEAD_BEEF, 32'h1234_5678));
        do_op(3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        i_start = 1'b1;
        i_op    = 3'b000;
        i_rs1   = 32'd99;
        i_rs2   = 32'd99;
        @(negedge clk);
        i_start = 1'b0;
        repeat (12) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_stall", 32'(o_stall), 32'd0);
        check("arst_busy", 32'(o_busy), 32'd0);
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_result", o_result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (o_valid || o_busy) begin
                check("arst_stays_idle", {31'h0, o_valid | o_busy}, 32'd0);
                break;
            end
        end

        // randomized operations against the reference model
        for (int n = 0; n < 48; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = rand_operand();
            b  = rand_operand();
            exp_q.push_back(ref_model(op, a, b));
            do_op(op, a, b, 1'b0);
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
